cmd_sequencer: RTL and testbench
================================

Name: cmd_sequencer

Overview:
- Sits between the UART receive/transmit byte streams and the command decoder/ALU pair of the pseudo-terminal.
- Assembles typed ASCII keystrokes into the 40-bit, 5-character command word the decoder consumes, then sequences the ALU.
- On a decoder `go`, it launches one ALU operation, waits for completion with a timeout, and returns the result to the terminal as hex digits plus CR.
- Also handles backspace, over-length lines, decoder reset and unknown commands.

Parameters:
- RESULT_W, 16, ALU result width; must be a multiple of 4; hex digits sent = RESULT_W/4.
- DEC_LAT, 2, cycles from command drive to sampling dec_go/dec_reset (decoder is registered).
- TIMEOUT, 1024, maximum cycles to wait for alu_done after alu_start.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- rx_data  in  8  received ASCII byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- command  out  40  5-char command; char0 in [39:32], char4 in [7:0].
- dec_go  in  1  decoder: valid ALU command.
- dec_reset  in  1  decoder: "reset" command recognised.
- alu_start  out  1  one-cycle launch pulse.
- alu_done  in  1  ALU completion pulse.
- alu_result  in  RESULT_W  ALU result, valid when alu_done.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until tx_ready.
- tx_ready  in  1  transmitter accepts.
- busy  out  1  high in any state except COLLECT.
- err  out  1  one-cycle pulse on overflow, unknown command or timeout.

Behaviour:
- Reset (reset_n=0 at posedge clk): state=COLLECT, char count=0, line buffer=all 0x20, overflow flag=0; command=0, alu_start=0, tx_valid=0, tx_data=0, err=0, busy=0. Reset mid-operation aborts at once; the ALU is not signalled.
- COLLECT:
  - rx_ready=1.
  - 0x08 decrements count if >0 and restores that slot to 0x20.
  - 0x0D with count=0 and no overflow is ignored.
  - 0x0D otherwise goes to ISSUE, or to TX_ERR if overflow.
  - Any other byte fills slot[count] and increments count if count<5; when count=5 it sets overflow instead and the byte is discarded.
- Padding: unused slots are 0x20, so "add" is issued as {a,d,d,0x20,0x20}.
- command drives the line buffer in ISSUE and EXEC, and 0 in every other state.
- ISSUE: count DEC_LAT cycles, then sample the decoder.
  - dec_reset=1 (priority over dec_go) → clear buffer → TX_CR.
  - dec_go=1 → pulse alu_start the same cycle → EXEC.
  - Neither → TX_ERR.
- EXEC:
  - alu_done → latch alu_result → TX_HEX, digit index = RESULT_W/4-1.
  - Cycle counter reaching TIMEOUT without done → TX_ERR.
  - alu_done arriving on the timeout cycle counts as done.
- TX_HEX: sends the digit for result[4i+3:4i], MSB digit first. Digits 0-9 map to 0x30-0x39, A-F to 0x41-0x46 (uppercase). After the last digit is accepted → TX_CR.
- TX_ERR: pulses err on entry, sends 0x3F ('?') → TX_CR.
- TX_CR: sends 0x0D, clears buffer/count/overflow → COLLECT.
- TX handshake:
  - tx_valid is registered; tx_data is stable while tx_valid=1 && tx_ready=0.
  - Advance only on tx_valid && tx_ready; at most one byte per cycle.
- rx_ready=0 outside COLLECT; rx bytes offered then are not consumed.
- err is also pulsed on the cycle the 6th character sets overflow.

Optional Feature:
- Macro CMD_SEQ_ECHO_EN.
- Defined:
  - Each byte accepted in COLLECT (including 0x08 and 0x0D) is echoed on tx through a one-byte echo register.
  - rx_ready=0 while that register holds an unsent byte.
  - An echoed 0x0D is sent before any response bytes.
- Undefined: no echo; tx is used only by response states, and rx_ready in COLLECT is 1 unconditionally.

Decomposition:
- Package cmd_seq_pkg holds:
  - state enum (COLLECT, ISSUE, EXEC, TX_HEX, TX_ERR, TX_CR);
  - ASCII constants (SPACE=0x20, CR=0x0D, BS=0x08, QMARK=0x3F);
  - CMD_CHARS=5.
- One sub-module, hex_to_ascii (4-bit nibble → 8-bit ASCII, combinational), instantiated once in the TX path.

Test Plan:
- Type "reset"+CR, decoder asserts dec_reset after DEC_LAT → command=0x7265736574 during ISSUE; tx emits only 0x0D; no alu_start.
- Type "add"+CR with dec_go=1, alu_done after 10 cycles with alu_result=0x1A2F → command=0x6164642020; one alu_start pulse; tx emits 0x31,0x41,0x32,0x46,0x0D.
- Type "abcdefg"+CR → err pulse at 'f'; nothing issued; tx emits 0x3F,0x0D; buffer cleared.
- Type "ab",0x08,"c"+CR, decoder gives neither flag → command=0x6163202020; err pulse; tx emits 0x3F,0x0D.
- dec_go=1 but alu_done never arrives → err after TIMEOUT cycles; tx emits 0x3F,0x0D. Also: tx_ready held low 20 cycles mid-hex → tx_data stable, no byte lost.
- reset_n low during EXEC → next cycle all outputs at reset values. With CMD_SEQ_ECHO_EN, "ab"+CR echoes 0x61,0x62,0x0D before the response.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command sequencer.
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        COLLECT,
        ISSUE,
        EXEC,
        TX_HEX,
        TX_ERR,
        TX_CR
    } state_t;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] QMARK = 8'h3F;

    localparam int CMD_CHARS = 5;

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Terminal command sequencer: line assembly, decoder handshake, ALU launch and hex reply.
// Optional keystroke echo is enabled by defining CMD_SEQ_ECHO_EN.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int RESULT_W = 16,
    parameter int DEC_LAT  = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [39:0]         command,
    input  logic                dec_go,
    input  logic                dec_reset,
    output logic                alu_start,
    input  logic                alu_done,
    input  logic [RESULT_W-1:0] alu_result,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                err
);

    localparam int DIGITS = RESULT_W / 4;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int LAT_W  = $clog2(DEC_LAT + 2);

    state_t                state_reg, state_next;
    logic [2:0]            count_reg;
    logic                  ovf_reg;
    logic [7:0]            line_buf [CMD_CHARS];
    logic [LAT_W-1:0]      lat_reg;
    logic [TMR_W-1:0]      tmr_reg;
    logic [RESULT_W-1:0]   result_reg;
    logic [DIG_W-1:0]      digit_reg;
    logic                  tx_valid_reg;
    logic [7:0]            tx_data_reg;
    logic                  tx_own_reg;
    logic                  err_reg;

    logic                  rx_fire, tx_fire, resp_sent, dec_sample, cr_go, ovf_set, err_next;
    logic [3:0]            nibble;
    logic [7:0]            hex_char;
    logic [8*CMD_CHARS-1:0] line_flat;

    for (genvar gi = 0; gi < CMD_CHARS; gi++) begin : g_flat
        assign line_flat[8*(CMD_CHARS-1-gi) +: 8] = line_buf[gi];
    end

`ifdef CMD_SEQ_ECHO_EN
    assign rx_ready = (state_reg == COLLECT) && !tx_valid_reg;
`else
    assign rx_ready = (state_reg == COLLECT);
`endif

    assign rx_fire    = rx_valid && rx_ready;
    assign tx_fire    = tx_valid_reg && tx_ready;
    // Only a byte loaded by a response state advances that state; echoes do not.
    assign resp_sent  = tx_fire && tx_own_reg;
    assign dec_sample = (state_reg == ISSUE) && (lat_reg == LAT_W'(DEC_LAT));
    assign cr_go      = (state_reg == COLLECT) && rx_fire && (rx_data == CR) &&
                        ((count_reg != 3'd0) || ovf_reg);
    assign ovf_set    = (state_reg == COLLECT) && rx_fire && (rx_data != BS) &&
                        (rx_data != CR) && (count_reg == 3'(CMD_CHARS)) && !ovf_reg;

    assign alu_start = reset_n && dec_sample && dec_go && !dec_reset;
    assign command   = ((state_reg == ISSUE) || (state_reg == EXEC)) ? line_flat : '0;
    assign busy      = (state_reg != COLLECT);
    assign err       = err_reg;
    assign tx_valid  = tx_valid_reg;
    assign tx_data   = tx_data_reg;

    assign nibble = 4'(result_reg >> {digit_reg, 2'b00});

    hex_to_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (cr_go) state_next = ovf_reg ? TX_ERR : ISSUE;
            ISSUE: begin
                if (dec_sample) begin
                    if (dec_reset)   state_next = TX_CR;
                    else if (dec_go) state_next = EXEC;
                    else             state_next = TX_ERR;
                end
            end
            EXEC: begin
                if (alu_done)                               state_next = TX_HEX;
                else if (tmr_reg == TMR_W'(TIMEOUT - 1))    state_next = TX_ERR;
            end
            TX_HEX:  if (resp_sent && (digit_reg == '0)) state_next = TX_CR;
            TX_ERR:  if (resp_sent) state_next = TX_CR;
            TX_CR:   if (resp_sent) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
        err_next = ((state_next == TX_ERR) && (state_reg != TX_ERR)) || ovf_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= COLLECT;
            count_reg    <= 3'd0;
            ovf_reg      <= 1'b0;
            lat_reg      <= '0;
            tmr_reg      <= '0;
            result_reg   <= '0;
            digit_reg    <= DIG_W'(DIGITS - 1);
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            tx_own_reg   <= 1'b0;
            err_reg      <= 1'b0;
            for (int i = 0; i < CMD_CHARS; i++) line_buf[i] <= SPACE;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (tx_fire) begin
                tx_valid_reg <= 1'b0;
                tx_own_reg   <= 1'b0;
            end
            case (state_reg)
                COLLECT: begin
                    lat_reg <= '0;
                    if (rx_fire) begin
`ifdef CMD_SEQ_ECHO_EN
                        tx_data_reg  <= rx_data;
                        tx_valid_reg <= 1'b1;
                        tx_own_reg   <= 1'b0;
`endif
                        if (rx_data == BS) begin
                            if (count_reg != 3'd0) begin
                                count_reg                  <= count_reg - 3'd1;
                                line_buf[count_reg - 3'd1] <= SPACE;
                            end
                        end else if (rx_data != CR) begin
                            if (count_reg < 3'(CMD_CHARS)) begin
                                line_buf[count_reg] <= rx_data;
                                count_reg           <= count_reg + 3'd1;
                            end else begin
                                ovf_reg <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    lat_reg <= lat_reg + 1'b1;
                    tmr_reg <= '0;
                end
                EXEC: begin
                    tmr_reg <= tmr_reg + 1'b1;
                    if (alu_done) begin
                        result_reg <= alu_result;
                        digit_reg  <= DIG_W'(DIGITS - 1);
                    end
                end
                TX_HEX: begin
                    if (!tx_valid_reg) begin
                        tx_data_reg  <= hex_char;
                        tx_valid_reg <= 1'b1;
                        tx_own_reg   <= 1'b1;
                    end else if (resp_sent) begin
                        digit_reg <= digit_reg - 1'b1;
                    end
                end
                TX_ERR: begin
                    if (!tx_valid_reg) begin
                        tx_data_reg  <= QMARK;
                        tx_valid_reg <= 1'b1;
                        tx_own_reg   <= 1'b1;
                    end
                end
                TX_CR: begin
                    if (!tx_valid_reg) begin
                        tx_data_reg  <= CR;
                        tx_valid_reg <= 1'b1;
                        tx_own_reg   <= 1'b1;
                    end else if (resp_sent) begin
                        count_reg <= 3'd0;
                        ovf_reg   <= 1'b0;
                        for (int i = 0; i < CMD_CHARS; i++) line_buf[i] <= SPACE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer with registered decoder and ALU models.
// Define CMD_SEQ_ECHO_EN for both bench and RTL to cover the echo build.
module tb_cmd_sequencer;

    localparam int RESULT_W = 16;
    localparam int DEC_LAT  = 2;
    localparam int TIMEOUT  = 1024;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_valid = 1'b0;
    logic                rx_ready;
    logic [39:0]         command;
    logic                dec_go = 1'b0;
    logic                dec_reset = 1'b0;
    logic                alu_start;
    logic                alu_done = 1'b0;
    logic [RESULT_W-1:0] alu_result = '0;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready = 1'b1;
    logic                busy;
    logic                err;

    logic [7:0]  exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          start_cnt = 0;
    int          err_cnt = 0;
    int          cmd_cycles = 0;
    int          cyc_cnt = 0;
    int          start_cyc = 0;
    int          err_cyc = 0;
    logic [39:0] last_cmd = '0;
    logic        alu_respond = 1'b1;
    logic [15:0] alu_val = '0;
    int          alu_cd = 0;
    logic        d1_go = 1'b0;
    logic        d1_rst = 1'b0;

    cmd_sequencer #(
        .RESULT_W (RESULT_W),
        .DEC_LAT  (DEC_LAT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .command    (command),
        .dec_go     (dec_go),
        .dec_reset  (dec_reset),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Two-stage registered decoder: "add  " and "sub  " are ALU commands.
    always @(posedge clk) begin
        if (!reset_n) begin
            d1_go <= 1'b0; d1_rst <= 1'b0; dec_go <= 1'b0; dec_reset <= 1'b0;
        end else begin
            d1_go     <= (command == 40'h6164642020) || (command == 40'h7375622020);
            d1_rst    <= (command == 40'h7265736574);
            dec_go    <= d1_go;
            dec_reset <= d1_rst;
        end
    end

    // ALU answers 10 cycles after launch unless alu_respond is low.
    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (!reset_n) begin
            alu_cd <= 0;
        end else if (alu_start && alu_respond) begin
            alu_cd <= 10;
        end else if (alu_cd > 0) begin
            alu_cd <= alu_cd - 1;
            if (alu_cd == 1) begin
                alu_done   <= 1'b1;
                alu_result <= alu_val;
            end
        end
    end

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (alu_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc_cnt;
        end
        if (err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc_cnt;
        end
        if (command != '0) begin
            last_cmd   <= command;
            cmd_cycles <= cmd_cycles + 1;
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check_val("tx_unexpected", {56'h0, tx_data}, 64'h100);
            end else begin
                check_val("tx_byte", {56'h0, tx_data}, {56'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic ok;
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
`ifdef CMD_SEQ_ECHO_EN
        exp_q.push_back(b);
`endif
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = rx_ready;
            n++;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check_val("rx_accept", {63'h0, ok}, 64'h1);
    endtask

    task automatic type_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic push_bytes(input logic [39:0] bytes, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(bytes[8*i +: 8]);
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int n = 0;
        while ((busy || tx_valid || exp_q.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_drain"}, 64'(exp_q.size()), 64'h0);
        check_val({tag, "_busy"}, {63'h0, busy}, 64'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_cmd"},      {24'h0, command}, 64'h0);
        check_val({tag, "_tx_valid"}, {63'h0, tx_valid}, 64'h0);
        check_val({tag, "_tx_data"},  {56'h0, tx_data}, 64'h0);
        check_val({tag, "_err"},      {63'h0, err}, 64'h0);
        check_val({tag, "_busy"},     {63'h0, busy}, 64'h0);
        check_val({tag, "_alu_start"},{63'h0, alu_start}, 64'h0);
        check_val({tag, "_rx_ready"}, {63'h0, rx_ready}, 64'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, e0, c0, n, lat;
        logic stable;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // "reset" command: only CR comes back, ALU untouched
        s0 = start_cnt; e0 = err_cnt;
        type_line("reset");
        send_byte(8'h0D);
        push_bytes(40'h0D, 1);
        wait_drain("reset_cmd", 200);
        check_val("reset_cmd_command", {24'h0, last_cmd}, 64'h7265736574);
        check_val("reset_cmd_starts", 64'(start_cnt - s0), 64'h0);
        check_val("reset_cmd_err", 64'(err_cnt - e0), 64'h0);

        // "add" with result 0x1A2F
        s0 = start_cnt; e0 = err_cnt; alu_val = 16'h1A2F;
        type_line("add");
        send_byte(8'h0D);
        push_bytes(40'h3141324630, 5);
        exp_q[4] = 8'h0D;
        wait_drain("add", 300);
        check_val("add_command", {24'h0, last_cmd}, 64'h6164642020);
        check_val("add_starts", 64'(start_cnt - s0), 64'h1);
        check_val("add_err", 64'(err_cnt - e0), 64'h0);

        // Overflow: err at 'f', then '?' on CR
        s0 = start_cnt; e0 = err_cnt; c0 = cmd_cycles;
        type_line("abcdef");
        repeat (3) @(negedge clk);
        check_val("ovf_err_at_f", 64'(err_cnt - e0), 64'h1);
        type_line("g");
        send_byte(8'h0D);
        push_bytes(40'h3F0D, 2);
        wait_drain("ovf", 200);
        check_val("ovf_err_total", 64'(err_cnt - e0), 64'h2);
        check_val("ovf_starts", 64'(start_cnt - s0), 64'h0);
        check_val("ovf_cmd_cycles", 64'(cmd_cycles - c0), 64'h0);

        // Backspace and unknown command
        s0 = start_cnt; e0 = err_cnt;
        type_line("ab");
        send_byte(8'h08);
        type_line("c");
        send_byte(8'h0D);
        push_bytes(40'h3F0D, 2);
        wait_drain("unknown", 200);
        check_val("unknown_command", {24'h0, last_cmd}, 64'h6163202020);
        check_val("unknown_err", 64'(err_cnt - e0), 64'h1);
        check_val("unknown_starts", 64'(start_cnt - s0), 64'h0);

        // Empty line is ignored
        s0 = start_cnt; e0 = err_cnt; c0 = cmd_cycles;
        send_byte(8'h0D);
        repeat (10) @(negedge clk);
        wait_drain("empty", 100);
        check_val("empty_err", 64'(err_cnt - e0), 64'h0);
        check_val("empty_cmd_cycles", 64'(cmd_cycles - c0), 64'h0);

        // ALU never answers: timeout
        s0 = start_cnt; e0 = err_cnt; alu_respond = 1'b0;
        type_line("sub");
        send_byte(8'h0D);
        push_bytes(40'h3F0D, 2);
        wait_drain("timeout", 3000);
        lat = err_cyc - start_cyc;
        check_val("timeout_starts", 64'(start_cnt - s0), 64'h1);
        check_val("timeout_err", 64'(err_cnt - e0), 64'h1);
        check_val("timeout_latency_ok", {63'h0, (lat >= TIMEOUT) && (lat <= TIMEOUT + 2)}, 64'h1);
        alu_respond = 1'b1;

        // tx_ready stalls for 20 cycles while the third digit is pending
        alu_val = 16'hBEEF;
        type_line("add");
        send_byte(8'h0D);
        push_bytes(40'h4245454630, 5);
        exp_q[exp_q.size() - 1] = 8'h0D;
        n = 0;
        while (exp_q.size() > 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        stable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (!tx_valid || tx_data != 8'h45) stable = 1'b0;
        end
        check_val("stall_data", {56'h0, tx_data}, 64'h45);
        check_val("stall_stable", {63'h0, stable}, 64'h1);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_drain("stall", 300);

        // Reset during EXEC aborts at once
        s0 = start_cnt; alu_val = 16'h1234;
        type_line("add");
        send_byte(8'h0D);
        n = 0;
        while (start_cnt == s0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("rst_exec_started", 64'(start_cnt - s0), 64'h1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("rst_exec");
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();
        repeat (30) @(negedge clk);
        check_val("rst_exec_starts", 64'(start_cnt - s0), 64'h1);
        check_val("rst_exec_busy", {63'h0, busy}, 64'h0);

        // Recovery with leading-zero digits
        alu_val = 16'h0009;
        type_line("add");
        send_byte(8'h0D);
        push_bytes(40'h3030303930, 5);
        exp_q[exp_q.size() - 1] = 8'h0D;
        wait_drain("recover", 300);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
